// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants and types for the 4-requester round-robin arbiter.
package rr_arbiter_4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    // Arbiter control state: waiting to arbitrate, or a requester owns the port.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage : rr_arbiter_4_pkg

// File: rtl/rr_arbiter_4_grant_decode.sv
// 2-to-4 decode of a winner index into a one-hot grant, gated by an enable.
module grant_decode
    import rr_arbiter_4_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    // Decode the index; all-zero whenever there is nothing to grant.
    always_comb begin
        onehot_o = 4'b0000;
        if (en_i) begin
            case (idx_i)
                2'd0:    onehot_o = 4'b0001;
                2'd1:    onehot_o = 4'b0010;
                2'd2:    onehot_o = 4'b0100;
                2'd3:    onehot_o = 4'b1000;
                default: onehot_o = 4'b0000;
            endcase
        end else begin
            onehot_o = 4'b0000;
        end
    end

endmodule : grant_decode

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and an
// optional hold limit that forcibly revokes a grant after MAX_HOLD cycles.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // First set request scanning last+1, last+2, last+3, last (mod 4), so the
    // requester served most recently has the lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] idx;
        rr_pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + IDX_W'(k);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    state_e               state_q,     state_d;
    logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
    logic [IDX_W-1:0]     gnt_id_q,    gnt_id_d;
    logic                 gnt_valid_q, gnt_valid_d;
    logic                 timeout_q,   timeout_d;
    logic [CNT_W-1:0]     hold_cnt_q,  hold_cnt_d;
    logic [IDX_W-1:0]     last_q,      last_d;

    logic [IDX_W-1:0]     winner_s;
    logic                 any_req_s;
    logic [NUM_REQ-1:0]   dec_gnt_s;

    assign winner_s  = rr_pick(req, last_q);
    assign any_req_s = |req;

    grant_decode u_grant_decode (
        .idx_i    (winner_s),
        .en_i     (any_req_s),
        .onehot_o (dec_gnt_s)
    );

    // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    gnt_d       = dec_gnt_s;
                    gnt_id_d    = winner_s;
                    gnt_valid_d = 1'b1;
                    last_d      = winner_s;
                    hold_cnt_d  = {CNT_W{1'b0}};
                    state_d     = ST_GRANT;
                end else begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id_q]) begin
                    // Normal release; wins over a simultaneous hold-limit hit.
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = {CNT_W{1'b0}};
                    state_d     = ST_IDLE;
                end else if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    hold_cnt_d  = {CNT_W{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    // Counter stays parked at zero when the limit is disabled.
                    hold_cnt_d  = HOLD_EN ? (hold_cnt_q + CNT_W'(1)) : {CNT_W{1'b0}};
                    state_d     = ST_GRANT;
                end
            end
            default: begin
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = {CNT_W{1'b0}};
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; everything clears asynchronously on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'b00;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= {CNT_W{1'b0}};
            last_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4: one instance with the default
// hold limit of 16 and one with a hold limit of 4.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req16, req4;
    logic [3:0] gnt16, gnt4;
    logic [1:0] id16, id4;
    logic       v16, v4, to16, to4;

    int vectors     = 0;
    int miscompares = 0;

    rr_arbiter_4 #(.MAX_HOLD(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req16),
        .gnt(gnt16), .gnt_id(id16), .gnt_valid(v16), .timeout(to16)
    );

    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4),
        .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4), .timeout(to4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: idx_of = 2'd1;
            4'b0100: idx_of = 2'd2;
            4'b1000: idx_of = 2'd3;
            default: idx_of = 2'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag,
                           input logic [3:0] g, input logic [1:0] id, input logic v, input logic t,
                           input logic [3:0] eg, input logic et);
        chk({tag, ".gnt"}, g, eg);
        chk({tag, ".valid"}, {3'b000, v}, {3'b000, (eg != 4'b0000)});
        chk({tag, ".timeout"}, {3'b000, t}, {3'b000, et});
        if (eg != 4'b0000) begin
            chk({tag, ".id"}, {2'b00, id}, {2'b00, idx_of(eg)});
        end
    endtask

    task automatic c16(input string tag, input logic [3:0] eg, input logic et);
        chk_out(tag, gnt16, id16, v16, to16, eg, et);
    endtask

    task automatic c4(input string tag, input logic [3:0] eg, input logic et);
        chk_out(tag, gnt4, id4, v4, to4, eg, et);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] eg;
        rst_n = 1'b0;
        req16 = 4'b0000;
        req4  = 4'b0000;
        #12;
        c16("reset16", 4'b0000, 1'b0);
        c4("reset4", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            tick;
            c16("idle", 4'b0000, 1'b0);
        end

        // All requesting: 0,1,2,3,0, each for 16 cycles, then a timeout cycle.
        req16 = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % 4);
            for (int c = 0; c < 16; c++) begin
                tick;
                c16("rr_hold", eg, 1'b0);
            end
            tick;
            c16("rr_timeout", 4'b0000, 1'b1);
        end
        req16 = 4'b0000;
        tick;
        c16("rr_idle", 4'b0000, 1'b0);

        // Short request from 2: three grant cycles, no timeout.
        req16 = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick;
            c16("short_hold", 4'b0100, 1'b0);
        end
        req16 = 4'b0000;
        tick;
        c16("short_rel", 4'b0000, 1'b0);
        tick;
        c16("short_idle", 4'b0000, 1'b0);

        // Serve 1, then 1 and 3 compete: 3 wins, then 1 after 3 times out.
        req16 = 4'b0010;
        tick;
        c16("serve1", 4'b0010, 1'b0);
        req16 = 4'b0000;
        tick;
        c16("serve1_rel", 4'b0000, 1'b0);
        req16 = 4'b1010;
        tick;
        c16("fair_3", 4'b1000, 1'b0);
        for (int c = 1; c < 16; c++) begin
            tick;
            c16("fair_3_hold", 4'b1000, 1'b0);
        end
        tick;
        c16("fair_3_to", 4'b0000, 1'b1);
        tick;
        c16("fair_1", 4'b0010, 1'b0);
        req16 = 4'b0000;
        tick;
        c16("fair_rel", 4'b0000, 1'b0);

        // Hold limit 4 with only requester 2: period of 5 cycles.
        req4 = 4'b0100;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                c4("h4_hold", 4'b0100, 1'b0);
            end
            tick;
            c4("h4_timeout", 4'b0000, 1'b1);
        end
        req4 = 4'b0000;
        tick;
        c4("h4_idle", 4'b0000, 1'b0);

        // Drop coincides with the last allowed hold cycle: plain release.
        req16 = 4'b0001;
        tick;
        c16("drop_grant0", 4'b0001, 1'b0);
        for (int c = 1; c < 16; c++) begin
            tick;
            c16("drop_hold", 4'b0001, 1'b0);
        end
        req16 = 4'b0000;
        tick;
        c16("drop_rel", 4'b0000, 1'b0);
        tick;
        c16("drop_idle", 4'b0000, 1'b0);

        // Reset in the middle of a grant to 2, checked before any clock edge.
        req16 = 4'b0100;
        tick;
        c16("pre_rst_grant", 4'b0100, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        c16("async_rst", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req16 = 4'b1111;
        tick;
        c16("post_rst_grant0", 4'b0001, 1'b0);
        req16 = 4'b0000;
        tick;
        c16("post_rst_rel", 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rr_arbiter_4

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- 4-requester round-robin arbiter for a shared resource.
- Winner index is converted to a one-hot grant by a 2-to-4 decode.
- Grants are registered and held until the owner drops its request, or until a configurable hold limit forces preemption.
- Sits between four bus masters and a single shared port; the one-hot grant drives the port mux selects directly.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; 0 disables the limit.
- CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- gnt  output  4  registered one-hot grant; all-zero when no owner.
- gnt_id  output  2  binary index of current owner; valid only while gnt_valid is high.
- gnt_valid  output  1  high while any grant is asserted (equals OR of gnt).
- timeout  output  1  one-cycle pulse in the cycle a grant is forcibly revoked by MAX_HOLD.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n low, independent of clk.
- Reset values:
  - gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0.
  - last=2'b11, so requester 0 has top priority after reset.
- State machine, two states:
  - IDLE: gnt=0.
    - If req!=0, pick the winner as the first set bit scanning (last+1), (last+2), (last+3), last, mod 4 with wrap-around.
    - On the next edge: gnt=decode(winner), gnt_id=winner, last=winner, hold_cnt=0, state=GRANT.
    - Request-to-grant latency is exactly 1 cycle.
  - GRANT: owner is gnt_id.
    - If req[gnt_id]=0 at an edge: gnt=0, state=IDLE, no timeout.
    - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: gnt=0, state=IDLE, timeout=1 for that one cycle.
    - Else hold_cnt increments and gnt is held.
    - Requests from other requesters are ignored while in GRANT; there is no mid-grant preemption.
- Turnaround: every release passes through exactly one IDLE cycle with gnt=0 before the next grant, so there is never back-to-back overlap of grants.
- Grant length: the owner holds gnt for at most MAX_HOLD cycles.
- Fairness:
  - The requester just served becomes lowest priority.
  - A timed-out requester still requesting is re-granted only if no other requester is active in the arbitration cycle.
- Simultaneous events: a request drop coinciding with hold_cnt==MAX_HOLD-1 is treated as a normal release, so timeout stays 0.
- hold_cnt saturates logically: it never wraps, because release occurs at MAX_HOLD-1.
- With MAX_HOLD=0, hold_cnt is held at 0 and is unused.
- Reset mid-grant: outputs go to reset values asynchronously and last returns to 2'b11. After rst_n deasserts, the first arbitration occurs on the first clock edge seen in IDLE.
- Output invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - When gnt_valid is high, gnt == decode(gnt_id).

Decomposition:
- Shared package/header constants: ST_IDLE=1'b0, ST_GRANT=1'b1, NUM_REQ=4.
- One natural sub-module, grant_decode: combinational 2-bit index plus enable in, 4-bit one-hot out, all-zero when enable is low. Instantiated once to produce the next gnt from the winner.
- The priority scan is a small combinational function in the top module.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout; assert rst_n low mid-cycle -> outputs clear without waiting for a clock edge.
- req=4'b1111 held, MAX_HOLD=16 -> grants in order 0,1,2,3,0. Each grant lasts 16 cycles, timeout pulses once per grant, and there is one gnt=0 cycle between grants.
- req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100 starts 1 cycle after req rises, lasts 3 cycles, then gnt=0; timeout never asserts.
- After requester 1 is served, req=4'b1010 -> next grant goes to requester 3 (scan order 2,3,0,1), then requester 1 on its next turn.
- Only req[2] held continuously with MAX_HOLD=4 -> gnt=4'b0100 for 4 cycles, timeout=1, 1 IDLE cycle, then requester 2 is re-granted. This repeats with a period of 5 cycles.
- req[0] drops in the same cycle hold_cnt==MAX_HOLD-1 -> gnt clears and timeout stays 0. Separately, reset asserted during a grant to requester 2, then req=4'b1111 -> first grant goes to requester 0.
